rr_arbiter4: RTL

- Round-robin arbiter that shares one 4-bit 4:1 mux datapath (and the resource behind it) among four requesters.
- Registers which requester owns the resource and drives the mux select from that owner.
- Holds the grant until the owner finishes, then rotates priority so that no requester starves.
- Sits between the requesting units and the shared mux in the demo1 datapath.

---
 rtl/arb_defs.sv | 22 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/rr_arbiter4.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/arb_defs.sv
// Shared definitions for the rr_arbiter4 round-robin arbiter:
// FSM encoding, requester count, index width and the default hold limit.
package arb_defs;

   // Arbiter states: no owner, or exactly one owner recorded in `owner`.
   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   localparam int NUM_REQ      = 4;
   localparam int IDX_W        = 2;

   // Default watchdog limit (consecutive cycles of ownership).
   localparam int MAX_HOLD_DEF = 15;

   // Binary requester index to one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: returns the first requester with
// its req bit set, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
   import arb_defs::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan the four candidates in rotated order; the first hit wins.
   always_comb begin
      any   = |req;
      idx   = ptr;
      cand  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ptr + IDX_W'(k);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter driving the select of a shared 4:1 mux.
// The owner keeps the grant until it pulses its done bit or drops its
// request; priority then rotates to the requester after the owner, and a
// pending requester takes over on the same edge (no idle cycle).
//
// Optional watchdog: define RR_ARB_WATCHDOG_EN to add a hold counter that
// forcibly releases an owner after MAX_HOLD cycles and pulses `timeout`.
// Without the macro there is no counter and `timeout` is constant 0.
module rr_arbiter4
   import arb_defs::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   done,
   output logic [NUM_REQ-1:0]   grant,
   output logic [IDX_W-1:0]     sel,
   output logic                 busy,
   output logic                 timeout
);

   arb_state_e           state_q, state_n;
   logic [IDX_W-1:0]     owner_q, owner_n;
   logic [IDX_W-1:0]     ptr_q,   ptr_n;
   logic [NUM_REQ-1:0]   grant_q, grant_n;

   logic [NUM_REQ-1:0]   pick_req;
   logic [IDX_W-1:0]     pick_ptr;
   logic                 pick_any;
   logic [IDX_W-1:0]     pick_idx;

   logic                 rel;
   logic                 expire;

   // One picker serves both the first grant from IDLE and the handoff on
   // release; the FSM decides which request view and pointer it sees.
   rr_pick4 u_pick (
      .req (pick_req),
      .ptr (pick_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Next-state logic: arbitration from IDLE, release and handoff from OWN.
   always_comb begin
      state_n  = state_q;
      owner_n  = owner_q;
      ptr_n    = ptr_q;
      rel      = 1'b0;
      pick_req = req;
      pick_ptr = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            // ptr is left alone on an initial grant; it only moves on release.
            if (pick_any) begin
               state_n = ARB_OWN;
               owner_n = pick_idx;
            end
         end
         ARB_OWN: begin
            // Only the owner's own bits matter; other req/done changes
            // never preempt it.
            rel      = done[owner_q] | ~req[owner_q] | expire;
            // The owner is masked out so others are offered first, and the
            // scan starts just past the owner (3 wraps to 0).
            pick_req = req & ~idx_onehot(owner_q);
            pick_ptr = owner_q + IDX_W'(1);
            if (rel) begin
               ptr_n = pick_ptr;
               if (pick_any) begin
                  owner_n = pick_idx;
               end else begin
                  state_n = ARB_IDLE;
               end
            end
         end
         default: begin
            state_n = ARB_IDLE;
         end
      endcase
      grant_n = (state_n == ARB_OWN) ? idx_onehot(owner_n) : '0;
   end

   // State, owner, pointer and grant registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         grant_q <= grant_n;
      end
   end

   // sel follows the registered owner, so it holds the last owner in IDLE.
   assign grant = grant_q;
   assign sel   = owner_q;
   assign busy  = (state_q == ARB_OWN);

`ifdef RR_ARB_WATCHDOG_EN
   localparam int              HOLD_W     = 8;
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] hold_cnt_q;
   logic              new_grant;
   logic              revoke;
   logic              timeout_q;

   // A new ownership starts either from IDLE or as a handoff on release.
   assign new_grant = (state_n == ARB_OWN) &&
                      ((state_q == ARB_IDLE) || rel);
   assign expire    = (state_q == ARB_OWN) && (hold_cnt_q == HOLD_LIMIT);
   // A release the owner asked for anyway is not reported as a timeout.
   assign revoke    = expire & ~done[owner_q] & req[owner_q];

   // Hold counter: cleared on each new grant, counts cycles spent in OWN.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= '0;
      end else if (new_grant) begin
         hold_cnt_q <= '0;
      end else if (state_q == ARB_OWN) begin
         hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
   end

   // Timeout pulse lines up with the handoff grant or the return to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= revoke;
      end
   end

   assign timeout = timeout_q;
`else
   // No watchdog: the owner holds until done or request drop.
   logic unused_max_hold;
   assign unused_max_hold = (MAX_HOLD != 0);
   assign expire          = 1'b0;
   assign timeout         = 1'b0;
`endif

endmodule
